periph_bus_fabric: RTL and testbench
====================================

Name: periph_bus_fabric

Overview:
Parametrised peripheral bus interconnect for the graphics generator. It replaces the hard-wired chip-select decode and the fixed read mux in the top level with N configurable address windows.
- Decode is priority-ordered, so overlapping windows resolve deterministically (e.g. the text window inside the BRAM range).
- A request/ready handshake routes one transaction at a time from the CPU bus to the selected peripheral.
- Each transaction ends in a ready or error pulse: unmapped addresses and slaves that never answer both return an error.

Parameters:
- NUM_SLAVES, 3, number of peripheral windows (1..8).
- AW, 32, address width.
- DW, 32, data width.
- SLV_BASE, {32'h40000000, 32'h00000000, 32'h0000FF00}, packed NUM_SLAVES*AW; slot i base in bits [i*AW +: AW].
- SLV_MASK, {32'hFF800000, 32'hFFFF0000, 32'hFFFFFF80}, packed; address bits compared for slot i.
- TIMEOUT_CYCLES, 255, WAIT cycles before abort (>=1).
- ERR_DATA, 32'hDEADBEEF, read data returned on error.

Ports:
- i_clk  in  1  bus/pixel clock.
- i_rst  in  1  synchronous, active-high reset.
- i_stb  in  1  master request, sampled only when o_busy=0.
- i_we  in  1  1=write, 0=read.
- i_addr  in  AW  master address.
- i_wdata  in  DW  master write data.
- o_rdata  out  DW  read data, valid while o_ready=1.
- o_ready  out  1  one-cycle completion pulse.
- o_err  out  1  high with o_ready when the transaction was unmapped or timed out.
- o_busy  out  1  transaction in progress.
- o_s_cs  out  NUM_SLAVES  one-hot slave select.
- o_s_stb  out  1  one-cycle strobe to the selected slave.
- o_s_we  out  1  registered write enable.
- o_s_addr  out  AW  registered offset (i_addr & ~SLV_MASK[sel]).
- o_s_wdata  out  DW  registered write data.
- i_s_rdata  in  NUM_SLAVES*DW  slave read data, packed.
- i_s_ready  in  NUM_SLAVES  slave completion.

Behaviour:
- Reset values: state IDLE; all outputs 0, including o_rdata and o_s_cs; timeout counter 0.
- Decode: slot i matches when (i_addr & MASK_i) == BASE_i.
  - The lowest matching index wins; with the defaults, slot 0 (text) beats slot 1 (BRAM) for 0000FF00..0000FF7F.
- IDLE, i_stb=1, mapped address (cycle 0): latch sel, we, offset, wdata.
  - Cycle 1: o_s_cs[sel]=1, o_s_stb=1 for exactly one cycle, state WAIT, o_busy=1.
- IDLE, i_stb=1, unmapped address: state DONE with err.
  - Cycle 1: o_ready=1, o_err=1, o_rdata=ERR_DATA; o_s_stb and o_s_cs stay 0.
- WAIT: i_s_ready[sel] is sampled from the o_s_stb cycle onward; i_s_ready on non-selected slots is ignored.
  - On ready: capture i_s_rdata[sel] (reads only; writes capture 0) and go to DONE.
- WAIT: counter increments once per WAIT cycle without ready.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with err, rdata=ERR_DATA.
- DONE: o_ready=1 for one cycle, o_err as latched; o_s_cs deasserted; next state IDLE.
- o_busy = (state != IDLE).
  - i_stb while busy is ignored (not queued).
  - The earliest next accept is the cycle after o_ready.
- Minimum latency, slave ready in the strobe cycle: accept at cycle 0, o_s_stb at 1, o_ready at 2.
- o_s_cs holds one-hot from the strobe cycle through the last WAIT cycle.
- Ready and timeout in the same cycle: ready wins, no error.
- i_rst mid-transaction: next cycle is IDLE with all outputs 0; no o_ready is issued for the aborted transaction.
- o_rdata holds its last value after o_ready falls.

Decomposition:
- Package periph_bus_pkg holds:
  - the state enum (ST_IDLE, ST_WAIT, ST_DONE);
  - the default ERR_DATA;
  - the default base/mask constants for text, BRAM and PSRAM.
- Sub-module periph_addr_match: combinational priority match of address against base/mask.
  - Outputs a one-hot hit vector, an index, and a valid flag.
  - Reusable by future DMA/blitter masters.

Test Plan:
- Read 0x00001234, BRAM slot asserts ready in the strobe cycle with rdata 0x000000A5:
  - o_s_cs=3'b010, o_s_addr=0x1234;
  - o_ready at cycle 2 with o_rdata=0xA5, o_err=0.
- Write 0x0000FF05 data 0x41:
  - o_s_cs=3'b001 (text wins over BRAM), o_s_addr=0x05, o_s_we=1, o_s_wdata=0x41;
  - o_ready with no error after the slave ready.
- Read 0x80000000 (unmapped):
  - no o_s_stb;
  - at cycle 1, o_ready=1, o_err=1, o_rdata=0xDEADBEEF.
- Read 0x40000010 with TIMEOUT_CYCLES=4 and the PSRAM slot never ready:
  - 4 WAIT cycles, then o_ready+o_err with o_rdata=0xDEADBEEF;
  - o_busy falls after the DONE cycle.
- Back-to-back stb held high during a transaction:
  - the held stb does not start a second transaction while o_busy=1;
  - a new transaction is accepted the cycle after o_ready;
  - spurious i_s_ready[2] during a slot-1 transaction is ignored.
- Assert i_rst for one cycle while in WAIT:
  - next cycle o_s_cs=0, o_busy=0;
  - o_ready never pulses for that transaction;
  - a fresh request then completes normally.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared types and default address map for the peripheral bus fabric.
// Holds the transaction state encoding, the error read pattern and the window constants.
// Contains no logic, so it has no latency and no backpressure.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    // Default windows. The text window sits inside the BRAM range and overrides it.
    localparam logic [31:0] TEXT_BASE  = 32'h0000FF00;
    localparam logic [31:0] TEXT_MASK  = 32'hFFFFFF80;
    localparam logic [31:0] BRAM_BASE  = 32'h00000000;
    localparam logic [31:0] BRAM_MASK  = 32'hFFFF0000;
    localparam logic [31:0] PSRAM_BASE = 32'h40000000;
    localparam logic [31:0] PSRAM_MASK = 32'hFF800000;

    // Width of a slot index. A single slot still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_addr_match.sv
// Priority address decoder: the lowest-numbered window whose masked base matches wins.
// Purely combinational (zero latency).
// Has no handshake, so backpressure does not apply.
module periph_addr_match
    import periph_bus_pkg::*;
#(
    parameter int                N    = 3,
    parameter int                AW   = 32,
    parameter logic [N*AW-1:0]   BASE = '0,
    parameter logic [N*AW-1:0]   MASK = '0,
    parameter int                IW   = idx_w(N)
) (
    input  logic [AW-1:0] addr_i,
    output logic [N-1:0]  hit_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    // Scan from the top down so that a lower index overwrites any higher match.
    always_comb begin
        hit_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((addr_i & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit_o    = '0;
                hit_o[i] = 1'b1;
                idx_o    = IW'(i);
                vld_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_bus_fabric.sv
// Routes one CPU bus transaction at a time to a peripheral selected by priority windows.
// Latency: strobe 1 cycle after accept, ready 1 cycle after slave ready (min 2); unmapped is 1 cycle.
// Requests arriving while o_busy=1 are dropped. Slaves stall freely until the timeout aborts them.
module periph_bus_fabric
    import periph_bus_pkg::*;
#(
    parameter int                         NUM_SLAVES     = 3,
    parameter int                         AW             = 32,
    parameter int                         DW             = 32,
    parameter logic [NUM_SLAVES*AW-1:0]   SLV_BASE       = {PSRAM_BASE, BRAM_BASE, TEXT_BASE},
    parameter logic [NUM_SLAVES*AW-1:0]   SLV_MASK       = {PSRAM_MASK, BRAM_MASK, TEXT_MASK},
    parameter int                         TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0]              ERR_DATA       = ERR_DATA_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_stb,
    input  logic                         i_we,
    input  logic [AW-1:0]                i_addr,
    input  logic [DW-1:0]                i_wdata,
    output logic [DW-1:0]                o_rdata,
    output logic                         o_ready,
    output logic                         o_err,
    output logic                         o_busy,
    output logic [NUM_SLAVES-1:0]        o_s_cs,
    output logic                         o_s_stb,
    output logic                         o_s_we,
    output logic [AW-1:0]                o_s_addr,
    output logic [DW-1:0]                o_s_wdata,
    input  logic [NUM_SLAVES*DW-1:0]     i_s_rdata,
    input  logic [NUM_SLAVES-1:0]        i_s_ready
);

    localparam int            IW       = idx_w(NUM_SLAVES);
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic [IW-1:0]           sel_q;
    logic [CW-1:0]           cnt_q;
    logic [DW-1:0]           rdata_q;
    logic                    ready_q;
    logic                    err_q;
    logic [NUM_SLAVES-1:0]   s_cs_q;
    logic                    s_stb_q;
    logic                    s_we_q;
    logic [AW-1:0]           s_addr_q;
    logic [DW-1:0]           s_wdata_q;

    logic [NUM_SLAVES-1:0]   m_hit;
    logic [IW-1:0]           m_idx;
    logic                    m_vld;
    logic [AW-1:0]           s_addr_d;
    logic                    sel_rdy;
    logic [DW-1:0]           sel_rdata;

    periph_addr_match #(
        .N    (NUM_SLAVES),
        .AW   (AW),
        .BASE (SLV_BASE),
        .MASK (SLV_MASK),
        .IW   (IW)
    ) u_match (
        .addr_i (i_addr),
        .hit_o  (m_hit),
        .idx_o  (m_idx),
        .vld_o  (m_vld)
    );

    // Slave-local offset: strip the window bits of the winning slot.
    always_comb begin
        s_addr_d = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (m_hit[i]) s_addr_d = i_addr & ~SLV_MASK[i*AW +: AW];
        end
    end

    // Only the latched slot may complete the transaction; other ready lines are ignored.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == IW'(i)) begin
                sel_rdy   = i_s_ready[i];
                sel_rdata = i_s_rdata[i*DW +: DW];
            end
        end
    end

    // Transaction FSM with registered outputs; ready beats timeout on the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            s_cs_q    <= '0;
            s_stb_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
        end else begin
            s_stb_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_stb) begin
                        if (m_vld) begin
                            state_q   <= ST_WAIT;
                            sel_q     <= m_idx;
                            cnt_q     <= '0;
                            s_cs_q    <= m_hit;
                            s_stb_q   <= 1'b1;
                            s_we_q    <= i_we;
                            s_addr_q  <= s_addr_d;
                            s_wdata_q <= i_wdata;
                        end else begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= ERR_DATA;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sel_rdy) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                        rdata_q <= s_we_q ? '0 : sel_rdata;
                        s_cs_q  <= '0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= ERR_DATA;
                        s_cs_q  <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    s_cs_q  <= '0;
                end
            endcase
        end
    end

    assign o_rdata   = rdata_q;
    assign o_ready   = ready_q;
    assign o_err     = err_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_s_cs    = s_cs_q;
    assign o_s_stb   = s_stb_q;
    assign o_s_we    = s_we_q;
    assign o_s_addr  = s_addr_q;
    assign o_s_wdata = s_wdata_q;

endmodule

// File: tb/tb_periph_bus_fabric.sv
// Bench for periph_bus_fabric: directed vectors, hand sequences and randomized traffic.
// Runs the DUT with a short timeout so abort paths are reached quickly.
// Slave readiness is driven as single-cycle pulses on a chosen slot.
module tb_periph_bus_fabric;

    localparam int NS = 3;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            i_rst, i_stb, i_we;
    logic [31:0]     i_addr, i_wdata;
    logic [31:0]     o_rdata;
    logic            o_ready, o_err, o_busy, o_s_stb, o_s_we;
    logic [NS-1:0]   o_s_cs;
    logic [31:0]     o_s_addr, o_s_wdata;
    logic [NS*32-1:0] i_s_rdata;
    logic [NS-1:0]   i_s_ready;
    logic [31:0]     srd [NS];

    assign i_s_rdata = {srd[2], srd[1], srd[0]};

    always #5 clk = ~clk;

    periph_bus_fabric #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_stb(i_stb), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ready(o_ready), .o_err(o_err),
        .o_busy(o_busy), .o_s_cs(o_s_cs), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_addr(o_s_addr), .o_s_wdata(o_s_wdata), .i_s_rdata(i_s_rdata),
        .i_s_ready(i_s_ready)
    );

    // Reference address map, written independently of the RTL package.
    logic [31:0] mb [NS] = '{32'h0000FF00, 32'h00000000, 32'h40000000};
    logic [31:0] mm [NS] = '{32'hFFFFFF80, 32'hFFFF0000, 32'hFF800000};

    typedef struct {
        logic [2:0]  cs;
        logic [31:0] saddr;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rs;
        int          rd;
        logic [31:0] rv;
        exp_t        e;
    } vec_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] rdata_after;
        logic [2:0]  cs1;
        logic [2:0]  cs_done;
        logic [31:0] saddr1;
        logic        swe1;
        logic [31:0] swdata1;
        int          stb_cnt;
        logic        busy_after;
    } res_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) if ((a & mm[i]) == mb[i]) return i;
        return -1;
    endfunction

    // Behavioural expectation: decode, then ready-before-timeout decides the outcome.
    function automatic exp_t ref_model(input logic we, input logic [31:0] a, input int rs, input int rd);
        exp_t e;
        int   idx;
        idx = ref_decode(a);
        if (idx < 0) begin
            e.cs = '0; e.saddr = '0; e.err = 1'b1; e.rdata = 32'hDEADBEEF; e.lat = 1;
        end else begin
            e.cs    = 3'(1 << idx);
            e.saddr = a & ~mm[idx];
            if (rs == idx && rd < TO) begin
                e.err = 1'b0; e.lat = rd + 2; e.rdata = we ? 32'h0 : srd[idx];
            end else begin
                e.err = 1'b1; e.lat = TO + 1; e.rdata = 32'hDEADBEEF;
            end
        end
        return e;
    endfunction

    // Issue one request (caller is in an IDLE cycle) and pulse slot rs ready rd cycles after strobe.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int rs, input int rd, output res_t r);
        r.lat = 0; r.err = 1'b0; r.rdata = '0; r.cs1 = '0; r.cs_done = '1;
        r.saddr1 = '0; r.swe1 = 1'b0; r.swdata1 = '0; r.stb_cnt = 0;
        i_stb = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
        step();
        i_stb = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (o_s_stb) r.stb_cnt++;
            if (n == 1) begin
                r.cs1 = o_s_cs; r.saddr1 = o_s_addr; r.swe1 = o_s_we; r.swdata1 = o_s_wdata;
            end
            if (o_ready) begin
                r.lat = n; r.err = o_err; r.rdata = o_rdata; r.cs_done = o_s_cs;
                break;
            end
            i_s_ready = '0;
            if (n - 1 == rd) i_s_ready[rs] = 1'b1;
            step();
        end
        i_s_ready = '0;
        step();
        r.busy_after  = o_busy;
        r.rdata_after = o_rdata;
    endtask

    task automatic verify(input string tag, input res_t r, input exp_t e,
                          input logic we, input logic [31:0] wdata);
        chk({tag, " latency"}, r.lat, e.lat);
        chk({tag, " err"}, {31'b0, r.err}, {31'b0, e.err});
        chk({tag, " rdata"}, r.rdata, e.rdata);
        chk({tag, " rdata_hold"}, r.rdata_after, e.rdata);
        chk({tag, " stb_count"}, r.stb_cnt, (e.cs != 0) ? 1 : 0);
        chk({tag, " cs"}, {29'b0, r.cs1}, {29'b0, e.cs});
        chk({tag, " cs_in_done"}, {29'b0, r.cs_done}, 32'h0);
        chk({tag, " busy_after"}, {31'b0, r.busy_after}, 32'h0);
        if (e.cs != 0) begin
            chk({tag, " s_addr"}, r.saddr1, e.saddr);
            chk({tag, " s_we"}, {31'b0, r.swe1}, {31'b0, we});
            chk({tag, " s_wdata"}, r.swdata1, wdata);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int rs, input int rd, input logic [31:0] rv,
                                input logic [2:0] cs, input logic [31:0] saddr, input logic err,
                                input logic [31:0] rdata, input int lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.rs = rs; v.rd = rd; v.rv = rv;
        v.e.cs = cs; v.e.saddr = saddr; v.e.err = err; v.e.rdata = rdata; v.e.lat = lat;
        return v;
    endfunction

    vec_t vt [9];
    res_t r;
    exp_t e;
    int   rdy_seen;

    initial begin
        vt[0] = mk(0, 32'h00001234, 32'h0,  1, 0,  32'h000000A5, 3'b010, 32'h1234,     0, 32'h000000A5, 2);
        vt[1] = mk(1, 32'h0000FF05, 32'h41, 0, 1,  32'h11111111, 3'b001, 32'h05,       0, 32'h0,        3);
        vt[2] = mk(0, 32'h80000000, 32'h0,  0, 0,  32'h0,        3'b000, 32'h0,        1, 32'hDEADBEEF, 1);
        vt[3] = mk(0, 32'h40000010, 32'h0,  2, 99, 32'h0,        3'b100, 32'h10,       1, 32'hDEADBEEF, 5);
        vt[4] = mk(0, 32'h0000FF80, 32'h0,  1, 3,  32'h12345678, 3'b010, 32'hFF80,     0, 32'h12345678, 5);
        vt[5] = mk(0, 32'h0000FF7F, 32'h0,  0, 2,  32'h0000CAFE, 3'b001, 32'h7F,       0, 32'h0000CAFE, 4);
        vt[6] = mk(0, 32'h407FFFFC, 32'h0,  2, 0,  32'h00000055, 3'b100, 32'h007FFFFC, 0, 32'h00000055, 2);
        vt[7] = mk(0, 32'h40800000, 32'h0,  0, 0,  32'h0,        3'b000, 32'h0,        1, 32'hDEADBEEF, 1);
        vt[8] = mk(0, 32'h00001000, 32'h0,  2, 0,  32'h00000077, 3'b010, 32'h1000,     1, 32'hDEADBEEF, 5);

        i_rst = 1'b1; i_stb = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_s_ready = '0;
        for (int k = 0; k < NS; k++) srd[k] = 32'hBAD00000 | k;
        step(); step();
        chk("reset rdata", o_rdata, 32'h0);
        chk("reset ready_err_busy_stb_we", {27'b0, o_ready, o_err, o_busy, o_s_stb, o_s_we}, 32'h0);
        chk("reset cs", {29'b0, o_s_cs}, 32'h0);
        chk("reset s_addr", o_s_addr, 32'h0);
        chk("reset s_wdata", o_s_wdata, 32'h0);
        i_rst = 1'b0;
        step();

        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < NS; k++) srd[k] = 32'hBAD00000 | k;
            srd[vt[v].rs] = vt[v].rv;
            run_txn(vt[v].we, vt[v].addr, vt[v].wdata, vt[v].rs, vt[v].rd, r);
            verify($sformatf("vec%0d", v), r, vt[v].e, vt[v].we, vt[v].wdata);
        end

        // Held request across a whole transaction, with a spurious ready from another slot.
        srd[1] = 32'h00000077; srd[0] = 32'h00000099;
        i_stb = 1'b1; i_we = 1'b0; i_addr = 32'h00001234;
        step();
        chk("b2b first stb", {31'b0, o_s_stb}, 32'h1);
        chk("b2b first cs", {29'b0, o_s_cs}, 32'h2);
        i_s_ready = 3'b100;
        step();
        chk("b2b spurious ready ignored", {30'b0, o_ready, o_s_stb}, 32'h0);
        chk("b2b busy in wait", {31'b0, o_busy}, 32'h1);
        i_s_ready = 3'b010;
        step();
        chk("b2b ready", {30'b0, o_ready, o_err}, 32'h2);
        chk("b2b rdata", o_rdata, 32'h77);
        chk("b2b no restrobe in done", {31'b0, o_s_stb}, 32'h0);
        i_s_ready = '0; i_addr = 32'h0000FF10;
        step();
        chk("b2b idle after done", {30'b0, o_busy, o_s_stb}, 32'h0);
        step();
        chk("b2b second stb", {31'b0, o_s_stb}, 32'h1);
        chk("b2b second cs", {29'b0, o_s_cs}, 32'h1);
        chk("b2b second s_addr", o_s_addr, 32'h10);
        i_stb = 1'b0; i_s_ready = 3'b001;
        step();
        i_s_ready = '0;
        chk("b2b second ready", {30'b0, o_ready, o_err}, 32'h2);
        chk("b2b second rdata", o_rdata, 32'h99);
        step();

        // Reset while waiting on a slave that never answers.
        i_stb = 1'b1; i_we = 1'b0; i_addr = 32'h40000010;
        step();
        i_stb = 1'b0;
        chk("rst strobe", {31'b0, o_s_stb}, 32'h1);
        step();
        chk("rst busy before", {31'b0, o_busy}, 32'h1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rst cs cleared", {29'b0, o_s_cs}, 32'h0);
        chk("rst flags cleared", {28'b0, o_busy, o_ready, o_err, o_s_stb}, 32'h0);
        chk("rst rdata cleared", o_rdata, 32'h0);
        rdy_seen = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (o_ready) rdy_seen++;
        end
        chk("rst no ready after abort", rdy_seen, 0);
        srd[1] = 32'h000000A5;
        run_txn(0, 32'h00001234, 32'h0, 1, 0, r);
        verify("after_rst", r, ref_model(0, 32'h00001234, 1, 0), 0, 32'h0);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            logic        we;
            logic [31:0] a, wd;
            int          rs, rd, idx;
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = 32'h0000FF00 | 32'($urandom_range(0, 255));
                2:       a = $urandom & 32'h0000FFFF;
                default: a = 32'h40000000 | ($urandom & 32'h00FFFFFF);
            endcase
            for (int k = 0; k < NS; k++) srd[k] = $urandom;
            idx = ref_decode(a);
            rs  = (idx >= 0 && $urandom_range(0, 3) != 0) ? idx : $urandom_range(0, NS - 1);
            rd  = $urandom_range(0, 6);
            e   = ref_model(we, a, rs, rd);
            run_txn(we, a, wd, rs, rd, r);
            verify($sformatf("rand%0d", t), r, e, we, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
